// File: rtl/stopwatch_ctrl_if.sv
// Button, counter and display signals shared between the stopwatch mode controller
// and its surroundings. The counter/button side is the master; the controller is the slave.
interface stopwatch_ctrl_if;
  logic       start_stop_btn;
  logic       lap_btn;
  logic [6:0] cs_in;
  logic [6:0] s_in;
  logic [6:0] m_in;
  logic       run;
  logic       clr;
  logic [1:0] state;
  logic [6:0] disp_cs;
  logic [6:0] disp_s;
  logic [6:0] disp_m;

  modport master (
    output start_stop_btn, lap_btn, cs_in, s_in, m_in,
    input  run, clr, state, disp_cs, disp_s, disp_m
  );

  modport slave (
    input  start_stop_btn, lap_btn, cs_in, s_in, m_in,
    output run, clr, state, disp_cs, disp_s, disp_m
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch button conditioning and mode control: two-flop synchronizers, per-button
// debouncers, press-edge detection, a four-state mode machine and the display latch.
module stopwatch_ctrl #(
  parameter int unsigned DEB_CYCLES = 20
) (
  input logic              new_clk,
  input logic              rst,
  stopwatch_ctrl_if.slave  io_bus
);

  localparam logic [1:0] StIdle  = 2'b00;
  localparam logic [1:0] StRun   = 2'b01;
  localparam logic [1:0] StPause = 2'b10;
  localparam logic [1:0] StLap   = 2'b11;

  // Toggle happens on the cycle the counter would reach DEB_CYCLES.
  localparam logic [7:0] DebLast = 8'(DEB_CYCLES - 1);

  // Bit 0 is start/stop, bit 1 is lap/reset.
  logic [1:0]      r_sync0;
  logic [1:0]      r_sync1;
  logic [1:0]      r_deb;
  logic [1:0]      r_deb_d;
  logic [1:0][7:0] r_cnt;

  logic [1:0] r_state;
  logic       r_run;
  logic       r_clr;
  logic [6:0] r_disp_cs;
  logic [6:0] r_disp_s;
  logic [6:0] r_disp_m;

  logic       w_ev_start;
  logic       w_ev_lap;
  logic [1:0] w_state_nxt;

  function automatic logic [6:0] clamp99(input logic [6:0] v);
    return (v > 7'd99) ? 7'd99 : v;
  endfunction

  // Two-flop synchronizers for the raw buttons.
  always_ff @(posedge new_clk or negedge rst) begin
    if (!rst) begin
      r_sync0 <= '0;
      r_sync1 <= '0;
    end else begin
      r_sync0 <= {io_bus.lap_btn, io_bus.start_stop_btn};
      r_sync1 <= r_sync0;
    end
  end

  // Debounce: accept a new level only after DEB_CYCLES consecutive differing samples.
  always_ff @(posedge new_clk or negedge rst) begin
    if (!rst) begin
      r_deb   <= '0;
      r_deb_d <= '0;
      r_cnt   <= '0;
    end else begin
      r_deb_d <= r_deb;
      for (int i = 0; i < 2; i++) begin
        if (r_sync1[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == DebLast) begin
          r_deb[i] <= ~r_deb[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 8'd1;
        end
      end
    end
  end

  // Press events; start/stop wins when both arrive in the same cycle.
  always_comb begin
    w_ev_start = r_deb[0] & ~r_deb_d[0];
    w_ev_lap   = r_deb[1] & ~r_deb_d[1] & ~w_ev_start;
  end

  // Mode machine next-state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle:  if (w_ev_start) w_state_nxt = StRun;
      StRun:   if (w_ev_start) w_state_nxt = StPause;
               else if (w_ev_lap) w_state_nxt = StLap;
      StPause: if (w_ev_start) w_state_nxt = StRun;
               else if (w_ev_lap) w_state_nxt = StIdle;
      StLap:   if (w_ev_start) w_state_nxt = StPause;
               else if (w_ev_lap) w_state_nxt = StRun;
      default: w_state_nxt = StIdle;
    endcase
  end

  // Mode state with registered enable and one-shot clear on PAUSE -> IDLE.
  always_ff @(posedge new_clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
      r_run   <= 1'b0;
      r_clr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_run   <= (w_state_nxt == StRun) || (w_state_nxt == StLap);
      r_clr   <= (r_state == StPause) && (w_state_nxt == StIdle);
    end
  end

  // Display follows the counters except while in LAP; the RUN->LAP edge itself loads
  // the counters, which freezes the lap value.
  always_ff @(posedge new_clk or negedge rst) begin
    if (!rst) begin
      r_disp_cs <= '0;
      r_disp_s  <= '0;
      r_disp_m  <= '0;
    end else if (r_state != StLap) begin
      r_disp_cs <= clamp99(io_bus.cs_in);
      r_disp_s  <= clamp99(io_bus.s_in);
      r_disp_m  <= clamp99(io_bus.m_in);
    end
  end

  assign io_bus.run     = r_run;
  assign io_bus.clr     = r_clr;
  assign io_bus.state   = r_state;
  assign io_bus.disp_cs = r_disp_cs;
  assign io_bus.disp_s  = r_disp_s;
  assign io_bus.disp_m  = r_disp_m;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed checks with hand-computed values plus a randomized
// run, all compared every cycle against a behavioural model of the stopwatch controls.
module tb_stopwatch_ctrl;
  localparam int unsigned DEB = 4;

  logic new_clk = 1'b0;
  logic rst     = 1'b0;
  always #5 new_clk = ~new_clk;

  stopwatch_ctrl_if u_if ();

  stopwatch_ctrl #(
    .DEB_CYCLES(DEB)
  ) u_dut (
    .new_clk(new_clk),
    .rst    (rst),
    .io_bus (u_if)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b1;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: button level accepted once the last DEB synced samples all
  // disagree with it; mode transitions from lookup tables; state codes 0..3.
  int m_s1[2], m_s2[2];
  int m_hist[2][$];
  int m_deb[2], m_debp[2];
  int m_state, m_run, m_clr;
  int m_disp[3];
  int next_on_start[4] = '{1, 2, 1, 2};
  int next_on_lap[4]   = '{0, 3, 0, 1};

  function automatic int clamp(input int v);
    return (v > 99) ? 99 : v;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      m_s1[b] = 0; m_s2[b] = 0; m_deb[b] = 0; m_debp[b] = 0;
      m_hist[b].delete();
    end
    m_state = 0; m_run = 0; m_clr = 0;
    for (int k = 0; k < 3; k++) m_disp[k] = 0;
  endtask

  task automatic model_step();
    int  ev_s, ev_l, prev, nxt;
    bit  all_diff;
    int  raw[2];
    ev_s = (m_deb[0] == 1 && m_debp[0] == 0) ? 1 : 0;
    ev_l = (m_deb[1] == 1 && m_debp[1] == 0 && ev_s == 0) ? 1 : 0;
    prev = m_state;
    nxt  = ev_s ? next_on_start[prev] : (ev_l ? next_on_lap[prev] : prev);
    m_clr   = (prev == 2 && nxt == 0) ? 1 : 0;
    m_run   = (nxt == 1 || nxt == 3) ? 1 : 0;
    m_state = nxt;
    if (prev != 3) begin
      m_disp[0] = clamp(int'(u_if.cs_in));
      m_disp[1] = clamp(int'(u_if.s_in));
      m_disp[2] = clamp(int'(u_if.m_in));
    end
    for (int b = 0; b < 2; b++) begin
      m_debp[b] = m_deb[b];
      m_hist[b].push_back(m_s2[b]);
      if (m_hist[b].size() > DEB) void'(m_hist[b].pop_front());
      all_diff = (m_hist[b].size() == DEB);
      foreach (m_hist[b][k]) if (m_hist[b][k] == m_deb[b]) all_diff = 1'b0;
      if (all_diff) m_deb[b] = 1 - m_deb[b];
    end
    raw[0] = int'(u_if.start_stop_btn);
    raw[1] = int'(u_if.lap_btn);
    for (int b = 0; b < 2; b++) begin
      m_s2[b] = m_s1[b];
      m_s1[b] = raw[b];
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge new_clk or negedge rst);
      if (!rst) model_reset();
      else model_step();
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge new_clk);
      if (chk_en) begin
        check("state",   int'(u_if.state),   m_state);
        check("run",     int'(u_if.run),     m_run);
        check("clr",     int'(u_if.clr),     m_clr);
        check("disp_cs", int'(u_if.disp_cs), m_disp[0]);
        check("disp_s",  int'(u_if.disp_s),  m_disp[1]);
        check("disp_m",  int'(u_if.disp_m),  m_disp[2]);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge new_clk);
  endtask

  task automatic press(input int which, input int hold, input int gap);
    if (which == 0) u_if.start_stop_btn = 1'b1;
    else u_if.lap_btn = 1'b1;
    tick(hold);
    if (which == 0) u_if.start_stop_btn = 1'b0;
    else u_if.lap_btn = 1'b0;
    tick(gap);
  endtask

  initial begin
    int clr_cnt;
    int saw_lap;
    int hold_left[2];

    u_if.start_stop_btn = 1'b0;
    u_if.lap_btn        = 1'b0;
    u_if.cs_in          = 7'd0;
    u_if.s_in           = 7'd0;
    u_if.m_in           = 7'd0;

    // Reset state and press latency (state changes exactly at edge DEB+3 = 7).
    tick(3);
    check("rst_state", int'(u_if.state), 0);
    check("rst_run",   int'(u_if.run),   0);
    rst = 1'b1;
    u_if.start_stop_btn = 1'b1;
    tick(6);
    check("pre_edge7_state", int'(u_if.state), 0);
    tick(1);
    check("edge7_state", int'(u_if.state), 1);
    check("edge7_run",   int'(u_if.run),   1);
    tick(49);
    check("held_no_repeat", int'(u_if.state), 1);
    u_if.start_stop_btn = 1'b0;
    tick(12);

    // Glitch rejection, then lap latch.
    press(1, 3, 12);
    check("lap_glitch", int'(u_if.state), 1);
    u_if.cs_in = 7'd37; u_if.s_in = 7'd12; u_if.m_in = 7'd5;
    press(1, 10, 0);
    check("lap_entry", int'(u_if.state), 3);
    for (int i = 0; i < 8; i++) begin
      u_if.cs_in = 7'($urandom_range(0, 127));
      u_if.s_in  = 7'($urandom_range(0, 127));
      u_if.m_in  = 7'($urandom_range(0, 127));
      tick(1);
    end
    check("lap_cs",  int'(u_if.disp_cs), 37);
    check("lap_s",   int'(u_if.disp_s),  12);
    check("lap_m",   int'(u_if.disp_m),  5);
    check("lap_run", int'(u_if.run),     1);

    // LAP -> PAUSE -> RUN -> PAUSE -> IDLE with clear pulse.
    press(0, 8, 10);
    check("lap_to_pause", int'(u_if.state), 2);
    check("pause_run",    int'(u_if.run),   0);
    press(0, 8, 10);
    check("pause_to_run", int'(u_if.state), 1);
    press(0, 8, 10);
    check("run_to_pause", int'(u_if.state), 2);
    clr_cnt = 0;
    u_if.lap_btn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 8) u_if.lap_btn = 1'b0;
      tick(1);
      if (u_if.clr) begin
        clr_cnt++;
        check("clr_in_idle", int'(u_if.state), 0);
      end
    end
    check("clr_once",     clr_cnt,           1);
    check("pause_to_idle", int'(u_if.state), 0);

    // Simultaneous events in RUN: start wins.
    press(0, 8, 10);
    saw_lap = 0;
    u_if.start_stop_btn = 1'b1;
    u_if.lap_btn        = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) begin
        u_if.start_stop_btn = 1'b0;
        u_if.lap_btn        = 1'b0;
      end
      tick(1);
      if (u_if.state == 2'b11) saw_lap = 1;
    end
    check("both_pause",  int'(u_if.state), 2);
    check("both_no_lap", saw_lap,          0);

    // Clamp in RUN.
    press(0, 8, 10);
    u_if.cs_in = 7'd120; tick(1);
    check("clamp_120", int'(u_if.disp_cs), 99);
    u_if.cs_in = 7'd99; tick(1);
    check("clamp_99", int'(u_if.disp_cs), 99);
    u_if.cs_in = 7'd0; tick(1);
    check("clamp_0", int'(u_if.disp_cs), 0);

    // Reset mid-LAP and mid-debounce; held button accepted DEB+3 edges after release.
    u_if.cs_in = 7'd50; u_if.s_in = 7'd20; u_if.m_in = 7'd10;
    press(1, 8, 4);
    check("lap_again", int'(u_if.state), 3);
    u_if.start_stop_btn = 1'b1;
    tick(3);
    #2 rst = 1'b0;
    #1;
    check("arst_state", int'(u_if.state),   0);
    check("arst_run",   int'(u_if.run),     0);
    check("arst_clr",   int'(u_if.clr),     0);
    check("arst_cs",    int'(u_if.disp_cs), 0);
    check("arst_s",     int'(u_if.disp_s),  0);
    check("arst_m",     int'(u_if.disp_m),  0);
    tick(2);
    rst = 1'b1;
    tick(6);
    check("post_rst_edge6", int'(u_if.state), 0);
    tick(1);
    check("post_rst_edge7", int'(u_if.state), 1);
    u_if.start_stop_btn = 1'b0;
    tick(12);

    // Randomized run against the model.
    hold_left[0] = 0;
    hold_left[1] = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold_left[0] == 0) begin
        u_if.start_stop_btn = 1'($urandom_range(0, 1));
        hold_left[0] = $urandom_range(1, 12);
      end
      if (hold_left[1] == 0) begin
        u_if.lap_btn = 1'($urandom_range(0, 1));
        hold_left[1] = $urandom_range(1, 12);
      end
      hold_left[0]--;
      hold_left[1]--;
      u_if.cs_in = 7'($urandom_range(0, 127));
      u_if.s_in  = 7'($urandom_range(0, 127));
      u_if.m_in  = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 599) == 0) begin
        #2 rst = 1'b0;
        tick(1);
        rst = 1'b1;
      end else begin
        tick(1);
      end
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
